// File: rtl/exp_range_reduce_pkg.sv
// Shared constants, types and helpers for the exp range-reduction wrapper.
// Holds fixed-point ln2 constants, bypass thresholds, bf16 special encodings,
// the FSM state enum and the input classifier used at operand acceptance.
package exp_range_reduce_pkg;

    localparam int BF_W = 16;

    // 1/ln2 as unsigned Q1.16 and ln2 as unsigned Q0.16
    localparam logic [16:0] INV_LN2_Q16 = 17'd94548;
    localparam logic [15:0] LN2_Q16     = 16'd45426;

    // Saturation / tiny-input thresholds (bf16 bit patterns and biased exponent)
    localparam logic [15:0] EXP_OVF_TH   = 16'h42B2;   //  89.0
    localparam logic [15:0] EXP_UNF_TH   = 16'hC2B0;   // -88.0
    localparam logic [7:0]  EXP_TINY_EXP = 8'd118;     // 2^-9

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] PINF    = 16'h7F80;
    localparam logic [15:0] ONE     = 16'h3F80;
    localparam logic [15:0] BF_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        RED_IDLE,
        RED_MUL,
        RED_SUB,
        RED_NORM,
        RED_ISSUE,
        RED_WAIT,
        RED_SCALE,
        RED_DONE
    } stateRED_t;

    typedef struct packed {
        logic        bypass;
        logic [15:0] value;
    } class_t;

    // Decide whether x can skip the CORDIC core entirely, and with what result.
    function automatic class_t classify(input logic [15:0] x);
        class_t c;
        c.bypass = 1'b1;
        c.value  = BF_ZERO;
        if (x[14:7] == 8'hFF && x[6:0] != 7'd0) begin
            c.value = QNAN;
        end else if (x[14:7] == 8'hFF) begin
            c.value = x[15] ? BF_ZERO : PINF;
        end else if (!x[15] && x >= EXP_OVF_TH) begin
            c.value = PINF;
        end else if (x[15] && x[14:0] >= EXP_UNF_TH[14:0]) begin
            c.value = BF_ZERO;
        end else if (x[14:7] < EXP_TINY_EXP) begin
            c.value = ONE;     // exp(x) rounds to 1.0 for |x| < 2^-9
        end else begin
            c.bypass = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/exp_range_reduce_if.sv
// Handshake bundle of exp_range_reduce.
// slave  : the range-reduction block's view (upstream in, downstream out, core side).
// master : the environment's view (source/sink and CORDIC core).
interface exp_range_reduce_if;
    import exp_range_reduce_pkg::*;

    logic            valid_i;
    logic [BF_W-1:0] data_i;
    logic            ready_o;
    logic            padv_i;
    logic            valid_o;
    logic [BF_W-1:0] data_o;
    logic            cor_valid_o;
    logic [BF_W-1:0] cor_data_o;
    logic            cor_ready_i;
    logic            cor_valid_i;
    logic [BF_W-1:0] cor_data_i;
    logic            cor_padv_o;

    modport slave (
        input  valid_i, data_i, padv_i, cor_ready_i, cor_valid_i, cor_data_i,
        output ready_o, valid_o, data_o, cor_valid_o, cor_data_o, cor_padv_o
    );

    modport master (
        output valid_i, data_i, padv_i, cor_ready_i, cor_valid_i, cor_data_i,
        input  ready_o, valid_o, data_o, cor_valid_o, cor_data_o, cor_padv_o
    );

endinterface

// File: rtl/exp_range_reduce_fix2bf16_norm.sv
// Combinational signed fixed-point to bfloat16 converter.
// fx_i : signed value with FB fractional bits (IW bits total, IW >= 10)
// bf_o : bfloat16, round-to-nearest-even on the 7-bit mantissa; zero maps to 0x0000
module fix2bf16_norm #(
    parameter int IW = 18,
    parameter int FB = 16
) (
    input  logic signed [IW-1:0] fx_i,
    output logic        [15:0]   bf_o
);
    localparam int LW = $clog2(IW);

    logic [IW-1:0] mag;
    logic [LW-1:0] msb;
    logic [IW-1:0] norm;
    logic [6:0]    mant;
    logic          guard;
    logic          sticky;
    logic [7:0]    mant_r;
    logic [9:0]    exp_w;

    always_comb begin
        mag = fx_i[IW-1] ? IW'(-fx_i) : IW'(fx_i);

        msb = '0;
        for (int i = 0; i < IW; i++) begin
            if (mag[i]) msb = LW'(i);
        end

        // Left-justify so the leading one sits at the top bit
        norm   = mag << (LW'(IW - 1) - msb);
        mant   = norm[IW-2 -: 7];
        guard  = norm[IW-9];
        sticky = |norm[IW-10:0];
        mant_r = {1'b0, mant} + {7'd0, guard & (sticky | mant[0])};

        // Mantissa carry-out bumps the exponent; mant_r[6:0] is then already zero
        exp_w = 10'(127 - FB) + 10'(msb) + 10'(mant_r[7]);

        bf_o = (mag == '0) ? 16'h0000 : {fx_i[IW-1], exp_w[7:0], mant_r[6:0]};
    end

endmodule

// File: rtl/exp_range_reduce.sv
// Range reduction around the CORDIC exp core: x = k*ln2 + r, the core
// evaluates exp(r), and k is added back onto the result exponent.
// Ports: clk, rst (sync, active high), bus (slave modport): upstream
// valid_i/data_i/ready_o, downstream valid_o/data_o/padv_i, and the core
// side cor_valid_o/cor_data_o/cor_ready_i, cor_valid_i/cor_data_i/cor_padv_o.
module exp_range_reduce
    import exp_range_reduce_pkg::*;
#(
    parameter int FRAC_BITS = 16,   // must be >= 16
    parameter int K_DW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    exp_range_reduce_if.slave bus
);
    localparam int MW   = FRAC_BITS + 8;    // |xf| magnitude width
    localparam int XW   = FRAC_BITS + 9;    // signed xf width
    localparam int PW   = MW + 17;          // |xf| * INV_LN2 product width
    localparam int RW   = FRAC_BITS + 2;    // signed r with one guard integer bit
    localparam int KMAX = (1 << (K_DW - 1)) - 1;
    localparam logic signed [XW:0] LN2_FX = (XW+1)'(LN2_Q16) << (FRAC_BITS - 16);

    stateRED_t               state_q, state_d;
    logic [15:0]             x_q, x_d;
    logic signed [XW-1:0]    xf_q, xf_d;
    logic signed [K_DW-1:0]  k_q, k_d;
    logic signed [RW-1:0]    rf_q, rf_d;
    logic [14:0]             cap_q, cap_d;
    logic                    valid_q, valid_d;
    logic [15:0]             data_q, data_d;
    logic                    cor_valid_q, cor_valid_d;
    logic [15:0]             cor_data_q, cor_data_d;
    logic                    cor_padv_q, cor_padv_d;

    class_t                  in_cls;
    logic [7:0]              sh;
    logic [MW-1:0]           xf_mag;
    logic [PW-1:0]           k_prod;
    logic [PW-1:0]           k_mag;
    logic signed [K_DW-1:0]  k_sat;
    logic signed [XW-1:0]    xf_sgn;
    logic [15:0]             r_bf;
    logic signed [9:0]       e_sum;
    logic [15:0]             scaled;

    assign in_cls = classify(bus.data_i);

    // MUL datapath. Non-bypassed inputs have biased exponent 118..133, so the
    // right shift below is 1..16 and |xf| stays under 2^(FRAC_BITS+7).
    always_comb begin
        sh     = 8'd134 - x_q[14:7];
        xf_mag = (MW'({1'b1, x_q[6:0]}) << FRAC_BITS) >> sh;
        xf_sgn = x_q[15] ? -XW'(xf_mag) : XW'(xf_mag);
        k_prod = PW'(xf_mag) * PW'(INV_LN2_Q16);
        // Rounding the magnitude gives round-half-away-from-zero after the sign is applied
        k_mag  = (k_prod + (PW'(1) << (FRAC_BITS + 15))) >> (FRAC_BITS + 16);
        if (!x_q[15]) begin
            k_sat = (k_mag > PW'(KMAX)) ? K_DW'(KMAX) : K_DW'(k_mag);
        end else begin
            k_sat = (k_mag > PW'(KMAX + 1)) ? K_DW'(-(KMAX + 1)) : -K_DW'(k_mag);
        end
    end

    fix2bf16_norm #(.IW(RW), .FB(FRAC_BITS)) u_norm (
        .fx_i (rf_q),
        .bf_o (r_bf)
    );

    // SCALE: exp(r) is positive, so only its exponent and mantissa matter
    always_comb begin
        e_sum = $signed({2'b00, cap_q[14:7]}) + 10'(k_q);
        if (e_sum >= 10'sd255) begin
            scaled = PINF;
        end else if (e_sum <= 10'sd0) begin
            scaled = BF_ZERO;
        end else begin
            scaled = {1'b0, e_sum[7:0], cap_q[6:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        xf_d        = xf_q;
        k_d         = k_q;
        rf_d        = rf_q;
        cap_d       = cap_q;
        valid_d     = valid_q;
        data_d      = data_q;
        cor_valid_d = cor_valid_q;
        cor_data_d  = cor_data_q;
        cor_padv_d  = 1'b0;

        case (state_q)
            RED_IDLE: begin
                if (bus.valid_i) begin
                    if (in_cls.bypass) begin
                        data_d  = in_cls.value;
                        valid_d = 1'b1;
                        state_d = RED_DONE;
                    end else begin
                        x_d     = bus.data_i;
                        state_d = RED_MUL;
                    end
                end
            end
            RED_MUL: begin
                xf_d    = xf_sgn;
                k_d     = k_sat;
                state_d = RED_SUB;
            end
            RED_SUB: begin
                rf_d    = RW'((XW+1)'(xf_q) - (XW+1)'(k_q) * LN2_FX);
                state_d = RED_NORM;
            end
            RED_NORM: begin
                cor_data_d  = r_bf;
                cor_valid_d = 1'b1;
                state_d     = RED_ISSUE;
            end
            RED_ISSUE: begin
                if (bus.cor_ready_i) begin
                    cor_valid_d = 1'b0;
                    state_d     = RED_WAIT;
                end
            end
            RED_WAIT: begin
                if (bus.cor_valid_i) begin
                    cap_d      = bus.cor_data_i[14:0];
                    cor_padv_d = 1'b1;
                    state_d    = RED_SCALE;
                end
            end
            RED_SCALE: begin
                data_d  = scaled;
                valid_d = 1'b1;
                state_d = RED_DONE;
            end
            RED_DONE: begin
                if (bus.padv_i) begin
                    valid_d = 1'b0;
                    state_d = RED_IDLE;
                end
            end
            default: state_d = RED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RED_IDLE;
            x_q         <= '0;
            xf_q        <= '0;
            k_q         <= '0;
            rf_q        <= '0;
            cap_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            cor_valid_q <= 1'b0;
            cor_data_q  <= '0;
            cor_padv_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            xf_q        <= xf_d;
            k_q         <= k_d;
            rf_q        <= rf_d;
            cap_q       <= cap_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            cor_valid_q <= cor_valid_d;
            cor_data_q  <= cor_data_d;
            cor_padv_q  <= cor_padv_d;
        end
    end

    assign bus.ready_o     = (state_q == RED_IDLE);
    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.cor_valid_o = cor_valid_q;
    assign bus.cor_data_o  = cor_data_q;
    assign bus.cor_padv_o  = cor_padv_q;

endmodule

// File: tb/tb_exp_range_reduce.sv
// Directed bench for exp_range_reduce with a hand-driven CORDIC core stub.
module tb_exp_range_reduce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exp_range_reduce_if bus();

    exp_range_reduce #(.FRAC_BITS(16), .K_DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_o"},     {15'd0, bus.valid_o},     16'h0);
        check({tag, "_data_o"},      bus.data_o,               16'h0);
        check({tag, "_cor_valid_o"}, {15'd0, bus.cor_valid_o}, 16'h0);
        check({tag, "_cor_data_o"},  bus.cor_data_o,           16'h0);
        check({tag, "_cor_padv_o"},  {15'd0, bus.cor_padv_o},  16'h0);
        check({tag, "_ready_o"},     {15'd0, bus.ready_o},     16'h1);
    endtask

    task automatic start_op(input logic [15:0] x);
        check("ready_before_op", {15'd0, bus.ready_o}, 16'h1);
        bus.valid_i = 1'b1;
        bus.data_i  = x;
        step();                                  // acceptance edge (end of T)
        bus.valid_i = 1'b0;
        bus.data_i  = 16'h0;
    endtask

    task automatic bypass_op(input logic [15:0] x, input logic [15:0] exp_out);
        start_op(x);
        check("byp_valid_T1", {15'd0, bus.valid_o}, 16'h1);
        check("byp_data_T1",  bus.data_o, exp_out);
        check("byp_no_core",  {15'd0, bus.cor_valid_o}, 16'h0);
        step();
        check("byp_no_core2", {15'd0, bus.cor_valid_o}, 16'h0);
        check("byp_hold",     {15'd0, bus.valid_o}, 16'h1);
        $display("bypass   x=%h data_o=%h", x, bus.data_o);
        bus.padv_i = 1'b1;
        step();
        bus.padv_i = 1'b0;
        check("byp_release", {15'd0, bus.valid_o}, 16'h0);
    endtask

    task automatic core_op(input logic [15:0] x, input logic [15:0] exp_cor, input int stall,
                           input logic [15:0] stub, input logic [15:0] exp_out, input int hold);
        start_op(x);
        check("cor_valid_T1", {15'd0, bus.cor_valid_o}, 16'h0);
        check("ready_busy",   {15'd0, bus.ready_o}, 16'h0);
        step();
        check("cor_valid_T2", {15'd0, bus.cor_valid_o}, 16'h0);
        step();
        check("cor_valid_T3", {15'd0, bus.cor_valid_o}, 16'h0);
        step();
        check("cor_valid_T4", {15'd0, bus.cor_valid_o}, 16'h1);
        check("cor_data_r",   bus.cor_data_o, exp_cor);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_cor_valid", {15'd0, bus.cor_valid_o}, 16'h1);
            check("stall_cor_data",  bus.cor_data_o, exp_cor);
        end
        bus.cor_ready_i = 1'b1;
        step();                                  // the one transfer
        bus.cor_ready_i = 1'b0;
        check("cor_valid_drop", {15'd0, bus.cor_valid_o}, 16'h0);
        step();
        check("cor_valid_once", {15'd0, bus.cor_valid_o}, 16'h0);
        bus.cor_valid_i = 1'b1;
        bus.cor_data_i  = stub;
        step();                                  // end of cycle C
        check("cor_padv_C1", {15'd0, bus.cor_padv_o}, 16'h1);
        check("valid_o_C1",  {15'd0, bus.valid_o}, 16'h0);
        bus.cor_valid_i = 1'b0;
        step();
        check("cor_padv_C2", {15'd0, bus.cor_padv_o}, 16'h0);
        check("valid_o_C2",  {15'd0, bus.valid_o}, 16'h1);
        check("data_o_C2",   bus.data_o, exp_out);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", {15'd0, bus.valid_o}, 16'h1);
            check("hold_data",  bus.data_o, exp_out);
            check("hold_ready", {15'd0, bus.ready_o}, 16'h0);
        end
        $display("core     x=%h r=%h stub=%h data_o=%h", x, bus.cor_data_o, stub, bus.data_o);
        bus.padv_i = 1'b1;
        step();
        bus.padv_i = 1'b0;
        check("release_valid", {15'd0, bus.valid_o}, 16'h0);
        check("release_ready", {15'd0, bus.ready_o}, 16'h1);
    endtask

    initial begin
        bus.valid_i     = 1'b0;
        bus.data_i      = 16'h0;
        bus.padv_i      = 1'b0;
        bus.cor_ready_i = 1'b0;
        bus.cor_valid_i = 1'b0;
        bus.cor_data_i  = 16'h0;

        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // 1.0 -> k=1, r=0.3069 ; -1.0 -> k=-1, r=-0.3069
        core_op(16'h3F80, 16'h3E9D, 0, 16'h3FAE, 16'h402E, 0);
        core_op(16'hBF80, 16'hBE9D, 0, 16'h3F3C, 16'h3EBC, 0);

        bypass_op(16'h7FC1, 16'h7FC0);
        bypass_op(16'hFF80, 16'h0000);
        bypass_op(16'h7F80, 16'h7F80);
        bypass_op(16'h42B2, 16'h7F80);
        bypass_op(16'hC2C0, 16'h0000);
        bypass_op(16'hC2B0, 16'h0000);
        bypass_op(16'h3A80, 16'h3F80);

        // 2.0 -> k=3, r=-5206/65536 rounds up to 0xBDA3; stalled core and stalled sink
        core_op(16'h4000, 16'hBDA3, 5, 16'h3F6C, 16'h40EC, 10);
        // 88.0 -> k=127; stub exponent 128 pushes e to 255 -> +inf
        core_op(16'h42B0, 16'hBCF2, 0, 16'h4000, 16'h7F80, 0);
        // -87.0 -> k=-126; stub exponent 126 gives e=0 -> flush to zero
        core_op(16'hC2AE, 16'h3EAC, 0, 16'h3F00, 16'h0000, 0);

        // Reset while waiting on the core, with the core result already valid
        start_op(16'h3F80);
        repeat (3) step();
        check("rw_cor_valid", {15'd0, bus.cor_valid_o}, 16'h1);
        bus.cor_ready_i = 1'b1;
        step();
        bus.cor_ready_i = 1'b0;
        bus.cor_valid_i = 1'b1;
        bus.cor_data_i  = 16'h3FAE;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst_wait");
        step();
        check("rw_ignored_padv",  {15'd0, bus.cor_padv_o}, 16'h0);
        check("rw_ignored_valid", {15'd0, bus.valid_o}, 16'h0);
        bus.cor_valid_i = 1'b0;
        $display("reset    during WAIT, outputs cleared");
        core_op(16'h3F80, 16'h3E9D, 0, 16'h3FAE, 16'h402E, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
